// File: rtl/i2c_master_controller_if.sv
// i2c_master_controller_if: command, status and SDA-module control signals of the I2C master controller
//   master modport: the controller (inputs Go/Address/RW/WriteData/ShiftIn, drives the rest)
//   slave modport : the user logic plus SDA module side of the same signals
interface i2c_master_controller_if;
    logic       Go;
    logic [6:0] Address;
    logic       RW;
    logic [7:0] WriteData;
    logic       ShiftIn;
    logic       SCL;
    logic       ReadorWrite;
    logic       Select;
    logic       StartStopAck;
    logic       ShiftOut;
    logic [7:0] ReadData;
    logic       Busy;
    logic       Done;
    logic       AckError;
    modport master (
        input  Go, Address, RW, WriteData, ShiftIn,
        output SCL, ReadorWrite, Select, StartStopAck, ShiftOut, ReadData, Busy, Done, AckError
    );
    modport slave (
        output Go, Address, RW, WriteData, ShiftIn,
        input  SCL, ReadorWrite, Select, StartStopAck, ShiftOut, ReadData, Busy, Done, AckError
    );
endinterface

// File: rtl/i2c_master_controller.sv
// i2c_master_controller: sequences one single-byte I2C master transaction (START, addr+R/W, ACK, data, ACK/NACK, STOP)
//   Clock, Reset : system clock, synchronous active-high reset
//   bus.Go/Address/RW/WriteData : transaction request, latched when Go is accepted in IDLE
//   bus.ShiftIn  : SDA value returned by the SDA module, sampled on the last cycle of Q2
//   bus.SCL/ReadorWrite/Select/StartStopAck/ShiftOut : SCL and SDA-module controls
//   bus.ReadData/Busy/Done/AckError : transaction status and result
module i2c_master_controller #(
    parameter int QUARTER = 250
) (
    input logic                    Clock,
    input logic                    Reset,
    i2c_master_controller_if.master bus
);
    localparam int QW = $clog2(QUARTER);
    typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP, DONE} state_t;
    state_t          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      phase_q, phase_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            ack_err_q, ack_err_d;
    logic            q_last, bit_end, sample, busy_st, rw;
    assign rw      = addr_q[0];
    assign q_last  = qcnt_q == QW'(QUARTER - 1);
    assign bit_end = q_last && phase_q == 2'd3;
    assign sample  = q_last && phase_q == 2'd2;
    assign busy_st = state_q != IDLE && state_q != DONE;
    always_comb begin
        state_d   = state_q;
        qcnt_d    = busy_st && !q_last ? qcnt_q + 1'b1 : '0;
        phase_d   = busy_st ? phase_q + (q_last ? 2'd1 : 2'd0) : 2'd0;
        bit_d     = bit_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        shift_d   = shift_q;
        rdata_d   = rdata_q;
        ack_err_d = ack_err_q;
        case (state_q)
            IDLE: if (bus.Go) begin
                addr_d    = {bus.Address, bus.RW};
                wdata_d   = bus.WriteData;
                ack_err_d = 1'b0;
                state_d   = START;
            end
            START: state_d = bit_end ? ADDR : START;
            ADDR: if (bit_end) begin
                bit_d   = bit_q + 3'd1;
                state_d = bit_q == 3'd7 ? ACK1 : ADDR;
            end
            ACK1: begin
                ack_err_d = ack_err_q | (sample & bus.ShiftIn);
                // an address NACK skips the data byte and goes straight to STOP
                if (bit_end) state_d = ack_err_q ? STOP : DATA;
            end
            DATA: begin
                if (sample && rw) shift_d = {shift_q[6:0], bus.ShiftIn};
                if (bit_end) begin
                    bit_d   = bit_q + 3'd1;
                    state_d = bit_q == 3'd7 ? ACK2 : DATA;
                end
            end
            ACK2: begin
                ack_err_d = ack_err_q | (sample & !rw & bus.ShiftIn);
                if (bit_end) begin
                    rdata_d = rw ? shift_q : rdata_q;
                    state_d = STOP;
                end
            end
            STOP: state_d = bit_end ? DONE : STOP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            qcnt_q    <= '0;
            phase_q   <= '0;
            bit_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            shift_q   <= '0;
            rdata_q   <= '0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            shift_q   <= shift_d;
            rdata_q   <= rdata_d;
            ack_err_q <= ack_err_d;
        end
    end
    // controls decode from state and phase only, so they move on phase boundaries; bit-indexed ones on Q0
    assign bus.SCL          = state_q inside {ADDR, ACK1, DATA, ACK2} ? phase_q[1] :
                              state_q == STOP ? phase_q != 2'd0 : 1'b1;
    assign bus.ReadorWrite  = state_q == ACK1 || (state_q == DATA && rw) || (state_q == ACK2 && !rw);
    assign bus.Select       = state_q == ADDR || (state_q == DATA && !rw);
    assign bus.StartStopAck = state_q == START ? !phase_q[1] : state_q == STOP ? phase_q[1] : 1'b1;
    assign bus.ShiftOut     = state_q == ADDR ? addr_q[~bit_q] :
                              state_q == DATA && !rw ? wdata_q[~bit_q] : 1'b0;
    assign bus.ReadData     = rdata_q;
    assign bus.Busy         = busy_st;
    assign bus.Done         = state_q == DONE;
    assign bus.AckError     = ack_err_q;
endmodule

// File: tb/tb_i2c_master_controller.sv
// tb_i2c_master_controller: randomized transactions against a bus-level slave/reference model
module tb_i2c_master_controller;
    localparam int Q = 2;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [7:0] rd_exp = 8'h00;
    i2c_master_controller_if bus();
    i2c_master_controller #(.QUARTER(Q)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));
    always #5 Clock = ~Clock;
    task automatic run_txn(input logic [6:0] a, input logic rw, input logic [7:0] wd, input logic [7:0] rd,
                           input logic a1, input logic a2, input bit keep_go, input int lead);
        int lat, n, k, bad, falls, rises, gcnt, ecnt;
        logic [15:0] exp_bits, got_bits;
        logic exp_err, ps, psel, pso, pdrv, plvl, drv, lvl;
        lat      = (a1 ? 44 * Q : 80 * Q) + 1 + lead;
        exp_err  = a1 | (!rw & a2);
        exp_bits = (!rw && !a1) ? {a, rw, wd} : {8'h00, a, rw};
        ecnt     = (!rw && !a1) ? 16 : 8;
        if (rw && !a1) rd_exp = rd;
        bus.Go = 1'b1;
        bus.Address = a;
        bus.RW = rw;
        bus.WriteData = wd;
        bus.ShiftIn = 1'b1;
        ps = bus.SCL; psel = bus.Select; pso = bus.ShiftOut;
        pdrv = !bus.ReadorWrite; plvl = bus.Select ? bus.ShiftOut : bus.StartStopAck;
        n = 0; k = 0; bad = 0; falls = 0; rises = 0; gcnt = 0; got_bits = '0;
        while (n < lat + 8) begin
            @(negedge Clock);
            n++;
            if (n == lead + 1) begin
                bus.Address = 7'($urandom);
                bus.RW = 1'($urandom);
                bus.WriteData = 8'($urandom);
            end
            if (!keep_go && n > lead) bus.Go = n < lat - 4 && $urandom_range(0, 3) == 0;
            if (lead > 0 && n == lead) begin
                checks++;
                if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_gap: busy=%b done=%b required 0 0", bus.Busy, bus.Done);
                end
            end
            if (n == lead + 1) begin
                checks++;
                if (bus.Busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_start: got %b required 1", bus.Busy);
                end
            end
            drv = !bus.ReadorWrite;
            lvl = bus.Select ? bus.ShiftOut : bus.StartStopAck;
            if (ps && bus.SCL) begin
                if (bus.Select !== psel || bus.ShiftOut !== pso) bad++;
                if (pdrv && drv && plvl && !lvl) falls++;
                if (pdrv && drv && !plvl && lvl) rises++;
            end
            if (!ps && bus.SCL && bus.Busy) begin
                if (!bus.ReadorWrite && bus.Select) begin
                    got_bits = {got_bits[14:0], bus.ShiftOut};
                    gcnt++;
                end
                if ((k == 8 || (k >= 9 && k <= 16 && rw && !a1) || (k == 17 && !rw)) && !bus.ReadorWrite) bad++;
                if (k == 17 && rw && (bus.ReadorWrite || bus.Select || !bus.StartStopAck)) bad++;
                k++;
            end
            if (ps && !bus.SCL && bus.Busy)
                bus.ShiftIn = k == 8 ? a1 : (k >= 9 && k <= 16 && rw && !a1) ? rd[16 - k] : (k == 17 && !rw) ? a2 : 1'b1;
            ps = bus.SCL; psel = bus.Select; pso = bus.ShiftOut; pdrv = drv; plvl = lvl;
            if (bus.Done) break;
        end
        checks++;
        if (n !== lat) begin
            errors++;
            $display("FAIL done_latency: got %0d cycles required %0d", n, lat);
        end
        checks++;
        if (bus.AckError !== exp_err) begin
            errors++;
            $display("FAIL ack_error: got %b required %b", bus.AckError, exp_err);
        end
        checks++;
        if (bus.ReadData !== rd_exp) begin
            errors++;
            $display("FAIL read_data: got %h required %h", bus.ReadData, rd_exp);
        end
        checks++;
        if (gcnt != ecnt || got_bits !== exp_bits) begin
            errors++;
            $display("FAIL shift_out: got %0d bits %h required %0d bits %h", gcnt, got_bits, ecnt, exp_bits);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bus_rules: got %0d violations required 0", bad);
        end
        checks++;
        if (falls != 1 || rises != 1) begin
            errors++;
            $display("FAIL start_stop: got falls=%0d rises=%0d required 1 1", falls, rises);
        end
        checks++;
        if ({bus.Busy, bus.SCL, bus.ReadorWrite, bus.Select, bus.StartStopAck, bus.ShiftOut} !== 6'b010010) begin
            errors++;
            $display("FAIL done_outputs: got %b required 010010",
                     {bus.Busy, bus.SCL, bus.ReadorWrite, bus.Select, bus.StartStopAck, bus.ShiftOut});
        end
        if (!keep_go) begin
            bus.Go = 1'b0;
            @(negedge Clock);
        end
    endtask
    task automatic test_reset();
        bus.Go = 1'b0; bus.Address = '0; bus.RW = 1'b0; bus.WriteData = '0; bus.ShiftIn = 1'b1;
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        checks++;
        if ({bus.SCL, bus.ReadorWrite, bus.Select, bus.StartStopAck, bus.ShiftOut, bus.Busy, bus.Done, bus.AckError} !== 8'b10010000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 10010000",
                     {bus.SCL, bus.ReadorWrite, bus.Select, bus.StartStopAck, bus.ShiftOut, bus.Busy, bus.Done, bus.AckError});
        end
        checks++;
        if (bus.ReadData !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata: got %h required 00", bus.ReadData);
        end
        Reset = 1'b0;
        @(negedge Clock);
    endtask
    task automatic test_write();
        run_txn(7'h50, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    endtask
    task automatic test_read();
        run_txn(7'h3C, 1'b1, 8'h00, 8'h96, 1'b0, 1'b0, 1'b0, 0);
    endtask
    task automatic test_addr_nack();
        run_txn(7'h2B, 1'b1, 8'h11, 8'h5A, 1'b1, 1'b0, 1'b0, 0);
        run_txn(7'h71, 1'b0, 8'hC3, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    endtask
    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_txn(7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                    $urandom_range(0, 3) == 0, 1'($urandom), 1'b0, 0);
    endtask
    task automatic test_reset_mid();
        bus.Go = 1'b1; bus.Address = 7'h1D; bus.RW = 1'b0; bus.WriteData = 8'h3E; bus.ShiftIn = 1'b0;
        for (int n = 1; n <= 52 * Q + 2; n++) begin
            @(negedge Clock);
            bus.Go = 1'b0;
        end
        checks++;
        if (bus.Busy !== 1'b1 || bus.ReadData !== rd_exp) begin
            errors++;
            $display("FAIL mid_busy: busy=%b rdata=%h required 1 %h", bus.Busy, bus.ReadData, rd_exp);
        end
        Reset = 1'b1;
        @(negedge Clock);
        rd_exp = 8'h00;
        checks++;
        if ({bus.SCL, bus.ReadorWrite, bus.Select, bus.StartStopAck, bus.ShiftOut, bus.Busy, bus.Done, bus.AckError, bus.ReadData} !== 16'b10010000_00000000) begin
            errors++;
            $display("FAIL mid_reset: got %b required 1001000000000000",
                     {bus.SCL, bus.ReadorWrite, bus.Select, bus.StartStopAck, bus.ShiftOut, bus.Busy, bus.Done, bus.AckError, bus.ReadData});
        end
        Reset = 1'b0;
        bus.ShiftIn = 1'b1;
        @(negedge Clock);
        run_txn(7'h44, 1'b0, 8'h9C, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    endtask
    task automatic test_back_to_back();
        run_txn(7'h0F, 1'b0, 8'h81, 8'h00, 1'b0, 1'b1, 1'b1, 0);
        run_txn(7'h62, 1'b1, 8'h00, 8'hE7, 1'b0, 1'b0, 1'b1, 1);
        run_txn(7'h33, 1'b0, 8'h5B, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    endtask
    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
